imi_data_wiper: RTL

IMI_DATA_WIPER -- requirements
Module: imi_data_wiper

---
 rtl/imi_wiper_pkg.sv | 15 +
 rtl/imi_wiper_fifo.sv | 65 ++++++
 rtl/imi_data_wiper.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/imi_wiper_pkg.sv
// Shared mode encoding and default sizing for the IMI data wiper.
package imi_wiper_pkg;

    localparam int IMI_WIPER_SYMB_W_DEF = 20;
    localparam int IMI_WIPER_DEPTH_DEF  = 4;
    localparam int IMI_WIPER_EPS_W_DEF  = 5;

    typedef enum logic [1:0] {
        IMI_WIPER_MODE_DATA     = 2'd0,
        IMI_WIPER_MODE_ZERO     = 2'd1,
        IMI_WIPER_MODE_MEANDER  = 2'd2,
        IMI_WIPER_MODE_DATA_XOR = 2'd3
    } imi_wiper_mode_e;

endpackage

// File: rtl/imi_wiper_fifo.sv
// Word FIFO with occupancy count; head word is presented combinationally.
module imi_wiper_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              push, pop;

    assign full    = (fill_q == FULL_LVL);
    assign empty   = (fill_q == '0);
    assign fill    = fill_q;
    assign rd_data = mem[rd_ptr_q];

    // Both qualifiers use the pre-edge count, so an empty FIFO never bypasses.
    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/imi_data_wiper.sv
// Serialises host words into an epoch-timed symbol stream with optional
// meander modulation, realigned by sync_pulse.
module imi_data_wiper
    import imi_wiper_pkg::*;
#(
    parameter int SYMB_W = IMI_WIPER_SYMB_W_DEF,
    parameter int DEPTH  = IMI_WIPER_DEPTH_DEF,
    parameter int EPS_W  = IMI_WIPER_EPS_W_DEF
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         epoch_pulse,
    input  logic                         sync_pulse,
    input  logic [1:0]                   cfg_mode,
    input  logic [EPS_W-1:0]             cfg_eps,
    input  logic [$clog2(SYMB_W+1)-1:0]  cfg_spw,
    input  logic                         wr_valid,
    input  logic [SYMB_W-1:0]            wr_data,
    output logic                         wr_ready,
    output logic                         data_symb,
    output logic                         symb_strobe,
    output logic [$clog2(DEPTH+1)-1:0]   fill,
    output logic                         underrun,
    input  logic                         clr_underrun
);

    localparam int SPW_W = $clog2(SYMB_W + 1);

    imi_wiper_mode_e    mode_q, mode_d;
    logic [EPS_W-1:0]   eps_q, eps_d;
    logic [SPW_W-1:0]   spw_q, spw_d;
    logic [EPS_W-1:0]   eps_cntr_q, eps_cntr_d;
    logic [SPW_W-1:0]   symb_cntr_q, symb_cntr_d;
    logic [SYMB_W-1:0]  shift_q, shift_d;
    logic               phase_q, phase_d;
    logic               data_symb_q, data_symb_d;
    logic               symb_strobe_q, symb_strobe_d;
    logic               underrun_q, underrun_d;

    logic               symb_bnd, word_bnd, load;
    logic [SYMB_W-1:0]  fifo_head;
    logic               fifo_full, fifo_empty;

    function automatic logic [SPW_W-1:0] clamp_spw(input logic [SPW_W-1:0] s);
        if (s == '0)                return SPW_W'(1);
        else if (s > SPW_W'(SYMB_W)) return SPW_W'(SYMB_W);
        else                        return s;
    endfunction

    function automatic logic symb_value(input imi_wiper_mode_e m, input logic d,
                                        input logic ph);
        case (m)
            IMI_WIPER_MODE_DATA:    return d;
            IMI_WIPER_MODE_ZERO:    return 1'b0;
            IMI_WIPER_MODE_MEANDER: return ph;
            default:                return d ^ ph;
        endcase
    endfunction

    assign symb_bnd = !sync_pulse && epoch_pulse && (eps_cntr_q == eps_q);
    assign word_bnd = symb_bnd && (symb_cntr_q == spw_q - 1'b1);
    assign load     = sync_pulse || word_bnd;

    imi_wiper_fifo #(
        .WIDTH (SYMB_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_valid),
        .wr_data (wr_data),
        .rd_en   (load),
        .rd_data (fifo_head),
        .fill    (fill),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        mode_d        = mode_q;
        eps_d         = eps_q;
        spw_d         = spw_q;
        eps_cntr_d    = eps_cntr_q;
        symb_cntr_d   = symb_cntr_q;
        shift_d       = shift_q;
        phase_d       = phase_q;
        data_symb_d   = data_symb_q;
        symb_strobe_d = 1'b0;
        underrun_d    = underrun_q && !clr_underrun;

        if (sync_pulse) begin
            mode_d      = imi_wiper_mode_e'(cfg_mode);
            eps_d       = cfg_eps;
            spw_d       = clamp_spw(cfg_spw);
            eps_cntr_d  = '0;
            symb_cntr_d = '0;
            phase_d     = 1'b0;
        end else if (epoch_pulse) begin
            phase_d = !phase_q;
            if (eps_cntr_q == eps_q) begin
                eps_cntr_d = '0;
                if (word_bnd) begin
                    symb_cntr_d = '0;
                end else begin
                    symb_cntr_d = symb_cntr_q + 1'b1;
                    shift_d     = shift_q >> 1;
                end
            end else begin
                eps_cntr_d = eps_cntr_q + 1'b1;
            end
        end

        // Output lags the shifter by one symbol: it shows the bit that was current
        // when the boundary arrived, under the config that governed that bit.
        if (sync_pulse || symb_bnd) begin
            data_symb_d   = symb_value(mode_q, shift_q[0], phase_q);
            symb_strobe_d = 1'b1;
        end

        if (load) begin
            if (fifo_empty) begin
                shift_d    = '0;
                underrun_d = 1'b1;
            end else begin
                shift_d = fifo_head;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q        <= IMI_WIPER_MODE_DATA;
            eps_q         <= '0;
            spw_q         <= SPW_W'(1);
            eps_cntr_q    <= '0;
            symb_cntr_q   <= '0;
            shift_q       <= '0;
            phase_q       <= 1'b0;
            data_symb_q   <= 1'b0;
            symb_strobe_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            eps_q         <= eps_d;
            spw_q         <= spw_d;
            eps_cntr_q    <= eps_cntr_d;
            symb_cntr_q   <= symb_cntr_d;
            shift_q       <= shift_d;
            phase_q       <= phase_d;
            data_symb_q   <= data_symb_d;
            symb_strobe_q <= symb_strobe_d;
            underrun_q    <= underrun_d;
        end
    end

    assign wr_ready    = !fifo_full;
    assign data_symb   = data_symb_q;
    assign symb_strobe = symb_strobe_q;
    assign underrun    = underrun_q;

endmodule
